// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam logic [2:0] ALIGN_MASK = 3'b111;
  localparam int TMO_W = 16;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic is_aligned(input logic [2:0] low_bits);
    return (low_bits & ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage and memory.
// Request: a beat transfers on a cycle where req_valid & req_ready; once raised, req_valid
// and its payload stay stable until that cycle. Response: resp_valid is a single-cycle ack/data beat.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit_req_channel.sv
// Request channel: holds req_valid/addr/wdata/write from launch until the ready handshake.
module mem_req_channel
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              abort,
  output logic              accepted,
  mem_access_unit_if.master bus
);

  assign accepted = bus.req_valid & bus.req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_wdata <= '0;
    end else if (start) begin
      bus.req_valid <= 1'b1;
      bus.req_write <= write;
      bus.req_addr  <= addr;
      bus.req_wdata <= wdata;
    end else if (accepted || abort) begin
      bus.req_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: doubleword load/store over a valid/ready bus, pipeline stall and writeback bundle.
// Optional response watchdog with bus_error output when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data_2_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite_in,
  input  logic [4:0]        write_register_in,
  output logic              stall,
  mem_access_unit_if.master bus,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              RegWrite_out,
  output logic [4:0]        write_register_out,
  output logic              align_fault,
  output state_t            fsm_state
`ifdef MEM_TIMEOUT_EN
  , output logic            bus_error
`endif
);

  state_t     state, next_state;
  logic       mem_op, aligned, start, accepted, timeout;
  logic       memtoreg_q, regwrite_q;
  logic [4:0] rd_q;

  assign mem_op    = in_valid & (MemRead | MemWrite);
  assign aligned   = is_aligned(alu_result_in[2:0]);
  assign fsm_state = state;

  // MemWrite wins when both MemRead and MemWrite are set.
  mem_req_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .write    (MemWrite),
    .addr     (alu_result_in),
    .wdata    (read_data_2_in),
    .abort    (timeout),
    .accepted (accepted),
    .bus      (bus)
  );

`ifdef MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (start) begin
      tmo_cnt <= '0;
    end else if (state != IDLE && tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus_error <= 1'b0;
    else        bus_error <= timeout;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     if (timeout) next_state = IDLE;
               else if (accepted) next_state = RESP;
      RESP:    if (timeout || bus.resp_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A timed-out access releases the pipeline on the same cycle, like a normal response.
  always_comb begin
    stall = 1'b0;
    start = 1'b0;
    case (state)
      IDLE: begin
        start = mem_op & aligned;
        stall = start;
      end
      REQ:     stall = !timeout;
      RESP:    stall = !(bus.resp_valid || timeout);
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid           <= 1'b0;
      wb_data            <= '0;
      RegWrite_out       <= 1'b0;
      write_register_out <= '0;
      align_fault        <= 1'b0;
      memtoreg_q         <= 1'b0;
      regwrite_q         <= 1'b0;
      rd_q               <= '0;
    end else begin
      wb_valid    <= 1'b0;
      align_fault <= 1'b0;
      if (timeout) begin
        wb_valid     <= 1'b1;
        wb_data      <= '0;
        RegWrite_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            if (!mem_op) begin
              wb_valid           <= 1'b1;
              wb_data            <= DATA_W'(alu_result_in);
              RegWrite_out       <= RegWrite_in;
              write_register_out <= write_register_in;
            end else if (!aligned) begin
              wb_valid           <= 1'b1;
              RegWrite_out       <= 1'b0;
              align_fault        <= 1'b1;
              write_register_out <= write_register_in;
            end else begin
              memtoreg_q <= MemtoReg;
              regwrite_q <= RegWrite_in;
              rd_q       <= write_register_in;
            end
          end
          // The held request address doubles as the latched ALU result.
          RESP: if (bus.resp_valid) begin
            wb_valid           <= 1'b1;
            wb_data            <= memtoreg_q ? bus.resp_rdata : DATA_W'(bus.req_addr);
            RegWrite_out       <= regwrite_q;
            write_register_out <= rd_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized instruction mix.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        chk_data;
    logic        regw;
    logic [4:0]  rd;
    logic        chk_rd;
    logic        fault;
  } wb_exp_t;
  localparam int EW = $bits(wb_exp_t);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid;
  logic [63:0] alu_result_in, read_data_2_in;
  logic        MemRead, MemWrite, MemtoReg, RegWrite_in;
  logic [4:0]  write_register_in;
  logic        stall, wb_valid, RegWrite_out, align_fault;
  logic [63:0] wb_data;
  logic [4:0]  write_register_out;
  state_t      fsm_state;
`ifdef MEM_TIMEOUT_EN
  logic        bus_error;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  wb_exp_t mon_e;

  always #5 clock = ~clock;

  mem_access_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_access_unit #(
    .ADDR_W(64), .DATA_W(64)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .alu_result_in      (alu_result_in),
    .read_data_2_in     (read_data_2_in),
    .MemRead            (MemRead),
    .MemWrite           (MemWrite),
    .MemtoReg           (MemtoReg),
    .RegWrite_in        (RegWrite_in),
    .write_register_in  (write_register_in),
    .stall              (stall),
    .bus                (bus.master),
    .wb_valid           (wb_valid),
    .wb_data            (wb_data),
    .RegWrite_out       (RegWrite_out),
    .write_register_out (write_register_out),
    .align_fault        (align_fault),
    .fsm_state          (fsm_state)
`ifdef MEM_TIMEOUT_EN
    , .bus_error        (bus_error)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard: every retired instruction must match the oldest expectation.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (wb_valid === 1'b1) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL wb_unexpected: observed wb_valid=1 expected no retirement");
        end
        if (exp_q.size() > 0) begin
          mon_e = wb_exp_t'(exp_q.pop_front());
          chk("wb_regwrite", RegWrite_out, mon_e.regw);
          chk("wb_align_fault", align_fault, mon_e.fault);
          if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
          if (mon_e.chk_rd) chk("wb_rd", write_register_out, mon_e.rd);
        end
      end else begin
        chk("fault_without_wb", align_fault, 1'b0);
      end
    end
  end

  task automatic push_exp(input wb_exp_t e);
    exp_q.push_back(EW'(e));
  endtask

  task automatic nonmem(input logic [63:0] alu, input logic rw, input logic [4:0] rd);
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'($urandom);
    alu_result_in = alu; read_data_2_in = rand64(); RegWrite_in = rw; write_register_in = rd;
    #1 chk("nonmem_stall", stall, 1'b0);
    push_exp('{data: alu, chk_data: 1'b1, regw: rw, rd: rd, chk_rd: 1'b1, fault: 1'b0});
    step();
  endtask

  task automatic misaligned(input logic [63:0] addr, input logic rd_n, input logic wr_n,
                            input logic [4:0] rd);
    in_valid = 1'b1; MemRead = rd_n; MemWrite = wr_n; MemtoReg = 1'b1;
    alu_result_in = addr; read_data_2_in = rand64(); RegWrite_in = 1'b1; write_register_in = rd;
    #1 chk("misalign_stall", stall, 1'b0);
    push_exp('{data: 64'd0, chk_data: 1'b0, regw: 1'b0, rd: rd, chk_rd: 1'b0, fault: 1'b1});
    step();
    chk("misalign_no_req", bus.req_valid, 1'b0);
  endtask

  task automatic do_mem(input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic rd_n, input logic wr_n, input logic m2r, input logic rw,
                        input logic [4:0] rd, input int rdy_dly, input int resp_dly);
    in_valid = 1'b1; MemRead = rd_n; MemWrite = wr_n; MemtoReg = m2r;
    alu_result_in = addr; read_data_2_in = wdata; RegWrite_in = rw; write_register_in = rd;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
    #1 chk("mem_stall_launch", stall, 1'b1);
    step();
    chk("req_valid_up", bus.req_valid, 1'b1);
    chk("req_write", bus.req_write, wr_n);
    chk("req_addr", bus.req_addr, addr);
    if (wr_n) chk("req_wdata", bus.req_wdata, wdata);
    for (int i = 0; i < rdy_dly; i++) begin
      #1 chk("stall_wait_ready", stall, 1'b1);
      step();
      chk("req_valid_hold", bus.req_valid, 1'b1);
      chk("req_addr_hold", bus.req_addr, addr);
    end
    bus.req_ready = 1'b1;
    #1 chk("stall_accept", stall, 1'b1);
    step();
    bus.req_ready = 1'b0;
    chk("req_valid_drop", bus.req_valid, 1'b0);
    for (int i = 0; i < resp_dly; i++) begin
      bus.resp_rdata = rand64();
      #1 chk("stall_wait_resp", stall, 1'b1);
      step();
    end
    bus.resp_valid = 1'b1; bus.resp_rdata = rdata;
    #1 chk("stall_resp", stall, 1'b0);
    push_exp('{data: (m2r ? rdata : addr), chk_data: 1'b1, regw: rw, rd: rd, chk_rd: 1'b1, fault: 1'b0});
    step();
    bus.resp_valid = 1'b0; bus.resp_rdata = rand64();
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; alu_result_in = '0; read_data_2_in = '0;
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite_in = 1'b0; write_register_in = '0;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;

    // Reset values
    #12;
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_req_write", bus.req_write, 1'b0);
    chk("rst_req_addr", bus.req_addr, 64'd0);
    chk("rst_req_wdata", bus.req_wdata, 64'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_regwrite", RegWrite_out, 1'b0);
    chk("rst_rd", write_register_out, 5'd0);
    chk("rst_align_fault", align_fault, 1'b0);
    chk("rst_state", 64'(fsm_state), 64'(IDLE));
    @(posedge clock); #1 reset = 1'b1;
    step();

    // Directed cases
    nonmem(64'h1234, 1'b1, 5'd5);
    in_valid = 1'b0;
    step();
    do_mem(64'h100, 64'h0, 64'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 2, 2);
    step();
    chk("single_wb_pulse", wb_valid, 1'b0);
    do_mem(64'h208, 64'hA5A5, 64'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 0, 1);
    misaligned(64'h103, 1'b1, 1'b0, 5'd3);
    in_valid = 1'b0;
    step();

    // Reset while waiting for a response, then a stale response arrives
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; alu_result_in = 64'h300;
    step();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    step();
    #1 reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_req_valid", bus.req_valid, 1'b0);
    chk("mid_rst_state", 64'(fsm_state), 64'(IDLE));
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    step();
    reset = 1'b1;
    bus.resp_valid = 1'b1; bus.resp_rdata = 64'hBAD;
    #1 chk("stale_resp_stall", stall, 1'b0);
    step();
    bus.resp_valid = 1'b0;
    chk("stale_resp_no_wb", wb_valid, 1'b0);
    chk("stale_resp_state", 64'(fsm_state), 64'(IDLE));
    step();

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: nonmem(rand64(), 1'($urandom), 5'($urandom));
        1: do_mem(rand64() & ~64'h7, rand64(), rand64(), 1'b1, 1'b0, 1'($urandom), 1'b1,
                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        2: do_mem(rand64() & ~64'h7, rand64(), rand64(), 1'($urandom), 1'b1, 1'b0, 1'b0,
                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        3: misaligned((rand64() & ~64'h7) | 64'($urandom_range(1, 7)), 1'b1, 1'($urandom),
                      5'($urandom));
        default: begin
          in_valid = 1'b0; alu_result_in = rand64(); MemRead = 1'($urandom);
          #1 chk("idle_stall", stall, 1'b0);
          step();
        end
      endcase
    end
    in_valid = 1'b0;
    step();

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: watchdog retires the access after 4 cycles
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1;
    alu_result_in = 64'h400; RegWrite_in = 1'b1; write_register_in = 5'd11;
    step();
    for (int i = 0; i < 3; i++) begin
      #1 chk("tmo_stall", stall, 1'b1);
      chk("tmo_bus_error_low", bus_error, 1'b0);
      step();
    end
    #1 chk("tmo_release_stall", stall, 1'b0);
    push_exp('{data: 64'd0, chk_data: 1'b1, regw: 1'b0, rd: 5'd0, chk_rd: 1'b0, fault: 1'b0});
    step();
    in_valid = 1'b0;
    chk("tmo_bus_error", bus_error, 1'b1);
    chk("tmo_req_drop", bus.req_valid, 1'b0);
    #1 chk("tmo_after_stall", stall, 1'b0);
    step();
    chk("tmo_bus_error_pulse", bus_error, 1'b0);
`endif

    step();
    step();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
